bp_be_roll_queue: RTL

- Parametrised FIFO between the frontend fetch stream and the backend checker.
- Supports speculative read, a separate commit step, rollback to the last committed entry, and full clear.
- Successor to the fixed single-dequeue FE queue. Generalised in depth, width and commit count (multi-entry commit per cycle), and adds a sticky protocol-error flag and an occupancy output.
- Sits at the FE/BE boundary. Consumes fetch packets; serves the checker's yumi/deq/roll/clr controls.

---
 rtl/bp_be_roll_queue.sv | 95 +++++++++
 1 files changed

// File: rtl/bp_be_roll_queue.sv
// Speculative-read FIFO between the fetch stream and the backend checker, with commit, rollback and clear.
// Optional same-cycle bypass from data_i to data_o is enabled by defining BP_BE_ROLL_QUEUE_BYPASS_EN.
module bp_be_roll_queue #(
   parameter int width_p   = 64,
   parameter int els_p     = 8,
   parameter int deq_els_p = 2
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic [width_p-1:0]             data_i,
   input  logic                           v_i,
   output logic                           ready_o,
   output logic [width_p-1:0]             data_o,
   output logic                           v_o,
   input  logic                           yumi_i,
   input  logic [$clog2(deq_els_p+1)-1:0] deq_cnt_i,
   input  logic                           roll_i,
   input  logic                           clr_i,
   output logic [$clog2(els_p+1)-1:0]     count_o,
   output logic                           error_o
);

   localparam int lg_els_lp = $clog2(els_p);
   localparam int ptr_w_lp  = lg_els_lp + 1;
   localparam int cnt_w_lp  = $clog2(els_p+1);

   logic [ptr_w_lp-1:0] wptr_r, rptr_r, cptr_r;
   logic [ptr_w_lp-1:0] wptr_n, rptr_n, cptr_n;
   logic [ptr_w_lp-1:0] occ, span, deq_ext;
   logic [width_p-1:0]  mem_r [els_p];
   logic                v_stored, enq_ok, yumi_ok, deq_ok;
   logic                err_enq, err_yumi, err_deq, error_r;

   // Pointers carry a wrap bit, so plain subtraction yields occupancy even across wrap.
   assign occ      = wptr_r - cptr_r;
   assign count_o  = cnt_w_lp'(occ);
   assign ready_o  = (occ != ptr_w_lp'(els_p));
   assign v_stored = (rptr_r != wptr_r);
   assign error_o  = error_r;

`ifdef BP_BE_ROLL_QUEUE_BYPASS_EN
   logic byp_v;
   assign byp_v  = ~v_stored & v_i & ready_o & ~clr_i & ~roll_i;
   assign v_o    = v_stored | byp_v;
   assign data_o = byp_v ? data_i : mem_r[rptr_r[lg_els_lp-1:0]];
`else
   assign v_o    = v_stored;
   assign data_o = mem_r[rptr_r[lg_els_lp-1:0]];
`endif

   assign enq_ok  = v_i & ready_o & ~clr_i;
   assign yumi_ok = yumi_i & v_o & ~roll_i & ~clr_i;
   // A commit may cover the entry being consumed in this same cycle.
   assign span    = (rptr_r + ptr_w_lp'(yumi_ok)) - cptr_r;
   assign deq_ext = ptr_w_lp'(deq_cnt_i);
   assign deq_ok  = ~clr_i & (deq_ext <= span);

   assign err_enq  = v_i & ~ready_o & ~clr_i;
   assign err_yumi = yumi_i & ~v_o & ~roll_i & ~clr_i;
   assign err_deq  = ~clr_i & (deq_ext > span);

   always_comb begin
      wptr_n = wptr_r;
      rptr_n = rptr_r;
      cptr_n = cptr_r;
      if (clr_i) begin
         rptr_n = wptr_r;
         cptr_n = wptr_r;
      end else begin
         wptr_n = wptr_r + ptr_w_lp'(enq_ok);
         cptr_n = deq_ok ? (cptr_r + deq_ext) : cptr_r;
         rptr_n = roll_i ? cptr_n : (rptr_r + ptr_w_lp'(yumi_ok));
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         cptr_r  <= '0;
         error_r <= 1'b0;
      end else begin
         wptr_r  <= wptr_n;
         rptr_r  <= rptr_n;
         cptr_r  <= cptr_n;
         error_r <= error_r | err_enq | err_yumi | err_deq;
      end
   end

   // Storage is written even on bypass so a later rollback can replay the entry.
   always_ff @(posedge clk_i) begin
      if (enq_ok) mem_r[wptr_r[lg_els_lp-1:0]] <= data_i;
   end

endmodule
